// File: rtl/lpm_pkg.sv
// Shared constants and elaboration helpers for the lpm_fifo family.
package lpm_pkg;

    localparam int LPM_DEF_WIDTH    = 8;
    localparam int LPM_DEF_NUMWORDS = 16;
    localparam int LPM_DEF_WIDTHU   = 4;

    // Ceiling log2; clog2(1) = 0. Used only on constants at elaboration.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lpm_fifo_mem.sv
// Simple dual-port storage for lpm_fifo: synchronous write port, registered read port.
module lpm_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             clr,
    input  logic             wren,
    input  logic [AW-1:0]    wraddr,
    input  logic [WIDTH-1:0] wrdata,
    input  logic             rden,
    input  logic [AW-1:0]    rdaddr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The array itself carries no reset; only the output register clears.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddr] <= wrdata;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (rden) begin
            q <= mem[rdaddr];
        end
    end

endmodule

// File: rtl/lpm_fifo.sv
// Single-clock FIFO with registered output and flags; any depth >= 2.
// Optional synchronous clear port sclr is built when LPM_FIFO_SCLR_EN is defined.
module lpm_fifo
    import lpm_pkg::*;
#(
    parameter lpm_type         = "lpm_fifo",
    parameter int lpm_width    = LPM_DEF_WIDTH,
    parameter int lpm_numwords = LPM_DEF_NUMWORDS,
    parameter int lpm_widthu   = LPM_DEF_WIDTHU,
    parameter lpm_hint         = "UNUSED"
) (
    input  logic                  clock,
    input  logic                  aclr_n,
`ifdef LPM_FIFO_SCLR_EN
    input  logic                  sclr,
`endif
    input  logic [lpm_width-1:0]  data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [lpm_width-1:0]  q,
    output logic                  empty,
    output logic                  full,
    output logic [lpm_widthu-1:0] usedw
);

    localparam int CW = clog2(lpm_numwords + 1);
    localparam int AW = clog2(lpm_numwords);

    if (lpm_width < 1 || lpm_numwords < 2 || (1 << lpm_widthu) < lpm_numwords) begin : g_bad_params
        $error("%s: illegal width/depth parameters, lpm_hint=%s", lpm_type, lpm_hint);
    end

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty_r;
    logic          full_r;
    logic          clr;
    logic          wr_acc;
    logic          rd_acc;

`ifdef LPM_FIFO_SCLR_EN
    assign clr = sclr;
`else
    assign clr = 1'b0;
`endif

    // Request/flag contract: wrreq is honoured only while full is low and
    // rdreq only while empty is low, both judged on the pre-edge flags, so
    // a write never feeds a same-edge read and a read never frees a same-edge write.
    assign wr_acc = wrreq & ~full_r & ~clr;
    assign rd_acc = rdreq & ~empty_r & ~clr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(lpm_numwords - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            count   <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == CW'(lpm_numwords));
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    lpm_fifo_mem #(
        .WIDTH (lpm_width),
        .DEPTH (lpm_numwords),
        .AW    (AW)
    ) u_mem (
        .clock  (clock),
        .aclr_n (aclr_n),
        .clr    (clr),
        .wren   (wr_acc),
        .wraddr (wr_ptr),
        .wrdata (data),
        .rden   (rd_acc),
        .rdaddr (rd_ptr),
        .q      (q)
    );

    assign empty = empty_r;
    assign full  = full_r;
    // usedw wraps to 0 when the depth equals 2**lpm_widthu and the FIFO is full.
    assign usedw = lpm_widthu'(count);

endmodule

// File: tb/tb_lpm_fifo.sv
// Bench for lpm_fifo (width 8, depth 4): directed table, corner sequences, random run vs queue model.
module tb_lpm_fifo;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int UW = 2;

    logic          clock  = 1'b0;
    logic          aclr_n = 1'b0;
    logic          wrreq  = 1'b0;
    logic          rdreq  = 1'b0;
    logic [W-1:0]  data   = '0;
`ifdef LPM_FIFO_SCLR_EN
    logic          sclr   = 1'b0;
`endif
    logic [W-1:0]  q;
    logic          empty;
    logic          full;
    logic [UW-1:0] usedw;

    int tests = 0;
    int fails = 0;

    // Scoreboard: exp_q holds the words the FIFO should contain, oldest first.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_out = '0;

    typedef struct {
        bit            wr;
        bit            rd;
        logic [W-1:0]  d;
        logic [W-1:0]  eq;
        bit            ee;
        bit            ef;
        logic [UW-1:0] eu;
    } vec_t;

    vec_t vecs[$];

    lpm_fifo #(
        .lpm_width    (W),
        .lpm_numwords (N),
        .lpm_widthu   (UW)
    ) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
`ifdef LPM_FIFO_SCLR_EN
        .sclr   (sclr),
`endif
        .data   (data),
        .wrreq  (wrreq),
        .rdreq  (rdreq),
        .q      (q),
        .empty  (empty),
        .full   (full),
        .usedw  (usedw)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit wr, input bit rd, input logic [W-1:0] d, input bit clr);
        bit rd_ok;
        bit wr_ok;
        if (clr) begin
            exp_q.delete();
            exp_out = '0;
            return;
        end
        rd_ok = rd && (exp_q.size() > 0);
        wr_ok = wr && (exp_q.size() < N);
        if (rd_ok) exp_out = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
    endtask

    task automatic check_model(input string name);
        check({name, "_q"},     32'(q),     32'(exp_out));
        check({name, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({name, "_full"},  32'(full),  32'(exp_q.size() == N));
        check({name, "_usedw"}, 32'(usedw), 32'(exp_q.size() % (1 << UW)));
    endtask

    // Drive one edge's inputs, advance past the edge, update model, compare.
    task automatic step(input string name, input bit wr, input bit rd, input logic [W-1:0] d,
                        input bit clr);
        wrreq = wr;
        rdreq = rd;
        data  = d;
`ifdef LPM_FIFO_SCLR_EN
        sclr  = clr;
`endif
        @(posedge clock);
        #1;
        model_edge(wr, rd, d, clr);
        check_model(name);
    endtask

    task automatic add_vec(input bit wr, input bit rd, input logic [W-1:0] d,
                           input logic [W-1:0] eq, input bit ee, input bit ef,
                           input logic [UW-1:0] eu);
        vec_t v;
        v.wr = wr; v.rd = rd; v.d = d; v.eq = eq; v.ee = ee; v.ef = ef; v.eu = eu;
        vecs.push_back(v);
    endtask

    initial begin
        // Fill to full, dropped 5th write, drain in order.
        add_vec(1, 0, 8'hA1, 8'h00, 0, 0, 2'd1);
        add_vec(1, 0, 8'hB2, 8'h00, 0, 0, 2'd2);
        add_vec(1, 0, 8'hC3, 8'h00, 0, 0, 2'd3);
        add_vec(1, 0, 8'hD4, 8'h00, 0, 1, 2'd0);
        add_vec(1, 0, 8'hE5, 8'h00, 0, 1, 2'd0);
        add_vec(0, 1, 8'h00, 8'hA1, 0, 0, 2'd3);
        add_vec(0, 1, 8'h00, 8'hB2, 0, 0, 2'd2);
        add_vec(0, 1, 8'h00, 8'hC3, 0, 0, 2'd1);
        add_vec(0, 1, 8'h00, 8'hD4, 1, 0, 2'd0);
        // Read+write on empty: read dropped, then the word comes out next.
        add_vec(1, 1, 8'h55, 8'hD4, 0, 0, 2'd1);
        add_vec(0, 1, 8'h00, 8'h55, 1, 0, 2'd0);
        // Read+write on full: only the read is taken; 99 never appears.
        add_vec(1, 0, 8'h11, 8'h55, 0, 0, 2'd1);
        add_vec(1, 0, 8'h22, 8'h55, 0, 0, 2'd2);
        add_vec(1, 0, 8'h33, 8'h55, 0, 0, 2'd3);
        add_vec(1, 0, 8'h44, 8'h55, 0, 1, 2'd0);
        add_vec(1, 1, 8'h99, 8'h11, 0, 0, 2'd3);
        add_vec(0, 1, 8'h00, 8'h22, 0, 0, 2'd2);
        add_vec(0, 1, 8'h00, 8'h33, 0, 0, 2'd1);
        add_vec(0, 1, 8'h00, 8'h44, 1, 0, 2'd0);
        add_vec(0, 1, 8'h00, 8'h44, 1, 0, 2'd0);

        // Clock/reset: check outputs while held in reset.
        aclr_n = 1'b0;
        #12;
        check("rst_q",     32'(q),     32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full",  32'(full),  32'h0);
        check("rst_usedw", 32'(usedw), 32'h0);
        @(negedge clock);
        aclr_n = 1'b1;

        foreach (vecs[i]) begin
            step("vec", vecs[i].wr, vecs[i].rd, vecs[i].d, 1'b0);
            check($sformatf("vec%0d_q", i),     32'(q),     32'(vecs[i].eq));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].ee));
            check($sformatf("vec%0d_full", i),  32'(full),  32'(vecs[i].ef));
            check($sformatf("vec%0d_usedw", i), 32'(usedw), 32'(vecs[i].eu));
        end

        // Half-full steady state: pointers wrap, count stays 2, order kept.
        step("hf_fill", 1, 0, 8'h01, 1'b0);
        step("hf_fill", 1, 0, 8'h02, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("hf_rw", 1, 1, W'(8'h10 + i), 1'b0);
            check("hf_usedw", 32'(usedw), 32'd2);
        end
        step("hf_drain", 0, 1, 8'h00, 1'b0);
        check("hf_last_q", 32'(q), 32'h18);
        step("hf_drain", 0, 1, 8'h00, 1'b0);
        check("hf_final_q", 32'(q), 32'h19);

        // Asynchronous reset between edges with 3 words stored and q nonzero.
        for (int i = 0; i < 4; i++) step("ar_fill", 1, 0, W'(8'hC0 + i), 1'b0);
        step("ar_rd", 0, 1, 8'h00, 1'b0);
        #2 aclr_n = 1'b0;
        #1;
        check("ar_q",     32'(q),     32'h0);
        check("ar_empty", 32'(empty), 32'h1);
        check("ar_full",  32'(full),  32'h0);
        check("ar_usedw", 32'(usedw), 32'h0);
        #1 aclr_n = 1'b1;
        exp_q.delete();
        exp_out = '0;
        step("ar_rd_drop", 0, 1, 8'h00, 1'b0);
        check("ar_rd_drop_empty", 32'(empty), 32'h1);

`ifdef LPM_FIFO_SCLR_EN
        step("sc_fill", 1, 0, 8'h31, 1'b0);
        step("sc_fill", 1, 1, 8'h32, 1'b0);
        step("sc_fill", 1, 0, 8'h33, 1'b0);
        step("sc_clr", 1, 0, 8'h34, 1'b1);
        check("sc_empty", 32'(empty), 32'h1);
        check("sc_usedw", 32'(usedw), 32'h0);
        check("sc_q",     32'(q),     32'h0);
        step("sc_after", 0, 1, 8'h00, 1'b0);
`endif

        // Randomized traffic with alternating write/read bias.
        for (int i = 0; i < 600; i++) begin
            int wp;
            bit wr;
            bit rd;
            bit clr;
            wp  = ((i / 40) % 2 == 0) ? 75 : 25;
            wr  = ($urandom_range(0, 99) < wp);
            rd  = ($urandom_range(0, 99) < (100 - wp));
            clr = 1'b0;
`ifdef LPM_FIFO_SCLR_EN
            clr = ($urandom_range(0, 63) == 0);
`endif
            step("rnd", wr, rd, W'($urandom), clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lpm_fifo.md
LPM_FIFO -- requirements
Module: lpm_fifo

Interface
- REQ-001 Parameter lpm_type, default "lpm_fifo": type identification string with no functional effect.
- REQ-002 Parameter lpm_width, default 8: data width in bits, minimum 1.
- REQ-003 Parameter lpm_numwords, default 16: depth in words, minimum 2, any integer (not limited to powers of two).
- REQ-004 Parameter lpm_widthu, default 4: usedw width; must satisfy 2**lpm_widthu >= lpm_numwords.
- REQ-005 Parameter lpm_hint, default "UNUSED": no functional effect.
- REQ-006 Port clock, input, 1: single clock; all state changes on its rising edge.
- REQ-007 Port aclr_n, input, 1: reset, asynchronous assert, active-low.
- REQ-008 Port data, input, lpm_width: write data.
- REQ-009 Port wrreq, input, 1: write request.
- REQ-010 Port rdreq, input, 1: read request.
- REQ-011 Port q, output, lpm_width: registered read data.
- REQ-012 Port empty, output, 1: FIFO holds zero words.
- REQ-013 Port full, output, 1: FIFO holds lpm_numwords words.
- REQ-014 Port usedw, output, lpm_widthu: current word count modulo 2**lpm_widthu.
- REQ-015 Port sclr, input, 1: synchronous clear; present only under LPM_FIFO_SCLR_EN.

Function
- REQ-016 Write acceptance: a write is accepted on an edge where wrreq=1 and full=0; otherwise it is dropped and state is unchanged.
- REQ-017 Read acceptance: a read is accepted on an edge where rdreq=1 and empty=0; otherwise it is dropped and state is unchanged.
- REQ-018 Flags are evaluated before the edge, so no fall-through occurs: a write to an empty FIFO does not enable a read on the same edge, and a read from a full FIFO does not enable a write on the same edge.
- REQ-019 Count on an edge:
  - write only: +1
  - read only: -1
  - both accepted: unchanged
- REQ-020 Read latency is 1 cycle: q takes the oldest word on the edge that accepts the read; q holds its value when no read is accepted.
- REQ-021 Ordering is strict FIFO; no word is lost or duplicated.
- REQ-022 Read and write pointers each run 0..lpm_numwords-1 and wrap from lpm_numwords-1 to 0.
- REQ-023 empty = (count==0), full = (count==lpm_numwords); both are registered and valid in the same cycle as count.
- REQ-024 usedw = count[lpm_widthu-1:0]; when lpm_numwords==2**lpm_widthu, usedw shows 0 while full=1.
- REQ-025 Storage write and read of the same address on the same edge are permitted only under REQ-018 rules; storage never returns a word written on the same edge.

Reset
- REQ-026 aclr_n=0 immediately forces:
  - q=0
  - empty=1, full=0, usedw=0
  - both pointers=0
- REQ-027 Reset asserted mid-transfer discards all stored words; the first edge after deassertion behaves as an empty FIFO.
- REQ-028 Memory contents are not reset.

Configuration
- REQ-029 With LPM_FIFO_SCLR_EN defined, port sclr exists. sclr=1 on an edge gives the same state as REQ-026 and takes priority over wrreq and rdreq on that edge.
- REQ-030 Without LPM_FIFO_SCLR_EN, port sclr is absent and the clear logic is not generated.

Structure
- REQ-031 Shared package lpm_pkg holds the default-width constants and a clog2 function used for the internal count width, which is clog2(lpm_numwords+1).
- REQ-032 Storage is one sub-module, lpm_fifo_mem: simple dual-port memory with one synchronous write port and one registered read port. All control logic stays in lpm_fifo.

Verification
Scenarios use width 8, numwords 4, widthu 2.
- REQ-033 Write A1,B2,C3,D4 on 4 consecutive edges -> full=1, usedw=0, empty=0. A 5th write of E5 is dropped, and 4 reads return A1,B2,C3,D4 with q valid 1 cycle after each accepted read.
- REQ-034 Read on an empty FIFO with wrreq=1 (data=55) on the same edge -> read dropped, q unchanged, usedw=1. The next read returns 55.
- REQ-035 Full FIFO with wrreq=1 and rdreq=1 on the same edge -> only the read is accepted, usedw=3, full=0.
- REQ-036 Half-full (count 2) with simultaneous wrreq and rdreq for 10 edges -> usedw stays 2, pointers wrap, output order is preserved.
- REQ-037 aclr_n pulsed low between clock edges with 3 words stored -> empty=1 and q=0 immediately, without waiting for a clock edge. A subsequent read is dropped.
- REQ-038 With LPM_FIFO_SCLR_EN defined: sclr=1 together with wrreq=1 at count 2 -> count=0 and empty=1 after the edge.
